// File: rtl/qif_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qif_pkg
//  Brief    : Shared types, default parameters and saturation helper for the
//             time-multiplexed QIF neuron array.
//  Revision : 1.0 - initial release
// ============================================================================
package qif_pkg;

  // Default parameter values for the neuron array
  localparam int QIF_WIDTH_DEF     = 8;
  localparam int QIF_N_NEURONS_DEF = 16;
  localparam int QIF_V_RESET_DEF   = -20;
  localparam int QIF_V_PEAK_DEF    = 50;
  localparam int QIF_SQ_SHIFT_DEF  = 6;
  localparam int QIF_I_SHIFT_DEF   = 2;
  localparam int QIF_REFRAC_DEF    = 2;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } qif_state_e;

  // Clamp a wide signed value into the signed range of a w-bit word.
  // The result is returned sign-extended; callers keep the low w bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                   input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qif_neuron_array_update.sv
`default_nettype none
// ============================================================================
//  Module   : qif_update
//  Brief    : Combinational QIF datapath: V + (V*V >>> SQ_SHIFT) +
//             (I >>> I_SHIFT) in 2*WIDTH+2 bits, saturated to WIDTH bits,
//             followed by the signed threshold compare against V_PEAK.
//  Revision : 1.0 - initial release
// ============================================================================
module qif_update
  import qif_pkg::*;
#(
  parameter int WIDTH    = QIF_WIDTH_DEF,
  parameter int SQ_SHIFT = QIF_SQ_SHIFT_DEF,
  parameter int I_SHIFT  = QIF_I_SHIFT_DEF,
  parameter int V_PEAK   = QIF_V_PEAK_DEF
) (
  input  logic signed [WIDTH-1:0] v_i,
  input  logic signed [WIDTH-1:0] syn_i,
  output logic signed [WIDTH-1:0] vs_o,
  output logic                    spike_o
);

  // Wide enough that the sum of all three terms can never wrap
  localparam int SW = 2 * WIDTH + 2;
  localparam logic signed [WIDTH-1:0] C_V_PEAK = WIDTH'(V_PEAK);

  logic signed [SW-1:0] w_v_ext;
  logic signed [SW-1:0] w_i_ext;
  logic signed [SW-1:0] w_sq;
  logic signed [SW-1:0] w_sum;
  logic signed [63:0]   w_sat;
  logic                 unused_sat_hi;

  assign w_v_ext = {{(SW - WIDTH){v_i[WIDTH-1]}}, v_i};
  assign w_i_ext = {{(SW - WIDTH){syn_i[WIDTH-1]}}, syn_i};

  // Square is non-negative; both shifts are arithmetic (floor)
  assign w_sq  = w_v_ext * w_v_ext;
  assign w_sum = w_v_ext + (w_sq >>> SQ_SHIFT) + (w_i_ext >>> I_SHIFT);

  assign w_sat         = sat_signed({{(64 - SW){w_sum[SW-1]}}, w_sum}, WIDTH);
  assign vs_o          = w_sat[WIDTH-1:0];
  assign unused_sat_hi = ^w_sat[63:WIDTH];

  assign spike_o = (vs_o >= C_V_PEAK);

endmodule
`default_nettype wire

// File: rtl/qif_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module   : qif_neuron_array
//  Brief    : Time-multiplexed array of N_NEURONS quadratic integrate-and-fire
//             neurons sharing one update datapath. Each step sweeps all
//             neurons: read synapse memory, update, spike detect, stream out.
//             Optional macro QIF_REFRACTORY_EN adds per-neuron refractory
//             counters (REFRAC steps of forced V_RESET after a spike).
//             rst_n is a synchronous, active-HIGH reset despite its name.
//  Revision : 1.0 - initial release
// ============================================================================
module qif_neuron_array
  import qif_pkg::*;
#(
  parameter int WIDTH     = QIF_WIDTH_DEF,
  parameter int N_NEURONS = QIF_N_NEURONS_DEF,
  parameter int V_RESET   = QIF_V_RESET_DEF,
  parameter int V_PEAK    = QIF_V_PEAK_DEF,
  parameter int SQ_SHIFT  = QIF_SQ_SHIFT_DEF,
  parameter int I_SHIFT   = QIF_I_SHIFT_DEF,
  parameter int REFRAC    = QIF_REFRAC_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           step,
  output logic                           syn_rd,
  output logic [$clog2(N_NEURONS)-1:0]   syn_addr,
  input  logic signed [WIDTH-1:0]        syn_data,
  output logic                           busy,
  output logic                           done,
  output logic                           out_valid,
  output logic [$clog2(N_NEURONS)-1:0]   out_idx,
  output logic signed [WIDTH-1:0]        v_out,
  output logic                           spike
);

  localparam int AW = $clog2(N_NEURONS);
  localparam logic signed [WIDTH-1:0] C_V_RESET = WIDTH'(V_RESET);
  localparam logic [AW-1:0]           C_LAST    = AW'(N_NEURONS - 1);

  // Controller
  qif_state_e        state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              done_q, done_d;

  // Stage 1: a read is outstanding, syn_data arrives this cycle
  logic              pend_valid_q;
  logic [AW-1:0]     pend_idx_q;

  // Stage 2: registered result
  logic              out_valid_q;
  logic [AW-1:0]     out_idx_q;
  logic signed [WIDTH-1:0] v_out_q, v_out_d;
  logic              spike_q, spike_d;

  // Per-neuron membrane state and its write-back value
  logic signed [WIDTH-1:0] v_q [N_NEURONS];
  logic signed [WIDTH-1:0] v_wb_d;

  logic signed [WIDTH-1:0] w_v_cur;
  logic signed [WIDTH-1:0] w_vs;
  logic                    w_spk;
  logic                    w_refrac;

  assign w_v_cur = v_q[pend_idx_q];

  qif_update #(
    .WIDTH    (WIDTH),
    .SQ_SHIFT (SQ_SHIFT),
    .I_SHIFT  (I_SHIFT),
    .V_PEAK   (V_PEAK)
  ) u_update (
    .v_i     (w_v_cur),
    .syn_i   (syn_data),
    .vs_o    (w_vs),
    .spike_o (w_spk)
  );

  // Next-state logic: walk the addresses, then wait for the last result
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (step) begin
          state_d = ST_READ;
          addr_d  = '0;
        end
      end
      ST_READ: begin
        if (addr_q == C_LAST) state_d = ST_DRAIN;
        else                  addr_d  = addr_q + AW'(1);
      end
      ST_DRAIN: begin
        // Last read has been consumed once no read is outstanding
        if (!pend_valid_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  // Result selection: refractory override, spike reset, or plain update
  always_comb begin
    v_out_d = v_out_q;
    spike_d = 1'b0;
    v_wb_d  = w_v_cur;
    if (pend_valid_q) begin
      if (w_refrac) begin
        v_out_d = C_V_RESET;
        v_wb_d  = C_V_RESET;
      end else begin
        v_out_d = w_vs;
        spike_d = w_spk;
        v_wb_d  = w_spk ? C_V_RESET : w_vs;
      end
    end
  end

  // Pipeline registers; outputs hold between results, spike is qualified
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      v_out_q      <= C_V_RESET;
      spike_q      <= 1'b0;
    end else begin
      pend_valid_q <= syn_rd;
      pend_idx_q   <= addr_q;
      out_valid_q  <= pend_valid_q;
      if (pend_valid_q) out_idx_q <= pend_idx_q;
      v_out_q      <= v_out_d;
      spike_q      <= spike_d;
    end
  end

  // Membrane write-back in the same cycle the result is registered
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) v_q[i] <= C_V_RESET;
    end else if (pend_valid_q) begin
      v_q[pend_idx_q] <= v_wb_d;
    end
  end

`ifdef QIF_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC + 1);
  localparam logic [RW-1:0] C_REFRAC = RW'(REFRAC);

  logic [RW-1:0] r_q [N_NEURONS];

  assign w_refrac = (r_q[pend_idx_q] != '0);

  // Refractory counters: load on spike, count down while non-zero
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) r_q[i] <= '0;
    end else if (pend_valid_q) begin
      if (w_refrac)   r_q[pend_idx_q] <= r_q[pend_idx_q] - RW'(1);
      else if (w_spk) r_q[pend_idx_q] <= C_REFRAC;
    end
  end
`else
  logic unused_refrac;
  assign w_refrac      = 1'b0;
  assign unused_refrac = (REFRAC > 0);
`endif

  assign syn_rd    = (state_q == ST_READ);
  assign syn_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign v_out     = v_out_q;
  assign spike     = spike_q;

endmodule
`default_nettype wire

// File: tb/tb_qif_neuron_array.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_qif_neuron_array
//  Brief    : Self-checking bench for qif_neuron_array (default parameters)
//             plus a two-neuron instance with V_PEAK=127 for saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qif_neuron_array;

  localparam int N  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n, step;
  logic syn_rd, busy, done, out_valid, spike;
  logic [AW-1:0] syn_addr, out_idx;
  logic signed [7:0] syn_data, v_out;

  logic step_s, syn_rd_s, busy_s, done_s, out_valid_s, spike_s;
  logic [0:0] syn_addr_s, out_idx_s;
  logic signed [7:0] syn_data_s, v_out_s;

  always #5 clk = ~clk;

  qif_neuron_array dut (
    .clk(clk), .rst_n(rst_n), .step(step),
    .syn_rd(syn_rd), .syn_addr(syn_addr), .syn_data(syn_data),
    .busy(busy), .done(done), .out_valid(out_valid), .out_idx(out_idx),
    .v_out(v_out), .spike(spike)
  );

  qif_neuron_array #(.N_NEURONS(2), .V_PEAK(127)) dut_sat (
    .clk(clk), .rst_n(rst_n), .step(step_s),
    .syn_rd(syn_rd_s), .syn_addr(syn_addr_s), .syn_data(syn_data_s),
    .busy(busy_s), .done(done_s), .out_valid(out_valid_s), .out_idx(out_idx_s),
    .v_out(v_out_s), .spike(spike_s)
  );

  // Synapse memory: one-cycle read latency
  logic signed [7:0] mem [N];
  always @(posedge clk) if (syn_rd) syn_data <= mem[syn_addr];

  int total = 0;
  int bad   = 0;
  int got_v [N];
  int got_sp[N];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  int mv[N];
`ifdef QIF_REFRACTORY_EN
  int mr[N];
`endif

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = -20;
`ifdef QIF_REFRACTORY_EN
      mr[k] = 0;
`endif
    end
  endfunction

  function automatic void model_step(input int k, input int din, output int vo, output int sp);
    int s;
`ifdef QIF_REFRACTORY_EN
    if (mr[k] > 0) begin
      vo = -20; sp = 0; mr[k] = mr[k] - 1;
      return;
    end
`endif
    s = mv[k] + ((mv[k] * mv[k]) >>> 6) + (din >>> 2);
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    vo = s;
    sp = (s >= 50) ? 1 : 0;
    mv[k] = (sp != 0) ? -20 : s;
`ifdef QIF_REFRACTORY_EN
    if (sp != 0) mr[k] = 2;
`endif
  endfunction

  // One full sweep with timing and data checks. Cycle c is sampled at the
  // falling edge after rising edge c-1; step is sampled at edge 0.
  task automatic run_sweep(input int extra_step, input bit chain_next, input bit started);
    int exp_v[N];
    int exp_sp[N];
    bit [19:0] rd_v, ov_v, dn_v, by_v, erd, eov, edn, eby, addr_err, idx_err, spk_err;
    rd_v = '0; ov_v = '0; dn_v = '0; by_v = '0;
    erd = '0; eov = '0; edn = '0; eby = '0;
    addr_err = '0; idx_err = '0; spk_err = '0;
    for (int k = 0; k < N; k++) begin
      model_step(k, int'(mem[k]), exp_v[k], exp_sp[k]);
      got_v[k] = 999; got_sp[k] = -1;
    end
    if (!started) begin
      @(negedge clk);
      step = 1'b1;
    end
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) step = 1'b0;
      rd_v[c] = syn_rd;    erd[c] = (c <= 16);
      if (syn_rd && syn_addr != AW'(c - 1)) addr_err[c] = 1'b1;
      ov_v[c] = out_valid; eov[c] = (c >= 3 && c <= 18);
      if (out_valid) begin
        if (out_idx != AW'(c - 3)) idx_err[c] = 1'b1;
        got_v[out_idx]  = int'(v_out);
        got_sp[out_idx] = int'(spike);
      end else if (spike) begin
        spk_err[c] = 1'b1;
      end
      dn_v[c] = done;      edn[c] = (c == 19);
      by_v[c] = busy;      eby[c] = (c <= 18);
      if (c == 19) chk("hold_v_out", int'(v_out), exp_v[N-1]);
      if (extra_step != 0 && c == extra_step) step = 1'b1;
      else if (extra_step != 0 && c == extra_step + 1) step = 1'b0;
      if (c == 19 && chain_next) step = 1'b1;
    end
    chk("syn_rd_pattern", int'(rd_v), int'(erd));
    chk("out_valid_pattern", int'(ov_v), int'(eov));
    chk("done_pattern", int'(dn_v), int'(edn));
    chk("busy_pattern", int'(by_v), int'(eby));
    chk("syn_addr_errors", int'(addr_err), 0);
    chk("out_idx_errors", int'(idx_err), 0);
    chk("spike_unqualified", int'(spk_err), 0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("v_out[%0d]", k), got_v[k], exp_v[k]);
      chk($sformatf("spike[%0d]", k), got_sp[k], exp_sp[k]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_syn_rd", int'(syn_rd), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_spike", int'(spike), 0);
    chk("rst_syn_addr", int'(syn_addr), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_v_out", int'(v_out), -20);
    rst_n = 1'b0;
  endtask

  // Directed step sequence: neuron 3 driven with in3, all others at zero
  typedef struct {
    int in3;
    int exp_v3;
    int exp_sp3;
    int exp_v0;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int sat_exp_v[4];
    int sat_exp_sp[4];
    int gv;
    int gs;

    tbl[0] = '{in3: 127, exp_v3: 17,  exp_sp3: 0, exp_v0: -14};
    tbl[1] = '{in3: 127, exp_v3: 52,  exp_sp3: 1, exp_v0: -11};
`ifdef QIF_REFRACTORY_EN
    tbl[2] = '{in3: 127, exp_v3: -20, exp_sp3: 0, exp_v0: -10};
    tbl[3] = '{in3: 127, exp_v3: -20, exp_sp3: 0, exp_v0: -9};
    tbl[4] = '{in3: 127, exp_v3: 17,  exp_sp3: 0, exp_v0: -8};
`else
    tbl[2] = '{in3: 127, exp_v3: 17,  exp_sp3: 0, exp_v0: -10};
    tbl[3] = '{in3: 127, exp_v3: 52,  exp_sp3: 1, exp_v0: -9};
    tbl[4] = '{in3: 127, exp_v3: 17,  exp_sp3: 0, exp_v0: -8};
`endif
    sat_exp_v[0] = 17;  sat_exp_v[1] = 52;  sat_exp_v[2] = 125; sat_exp_v[3] = 127;
    sat_exp_sp[0] = 0;  sat_exp_sp[1] = 0;  sat_exp_sp[2] = 0;  sat_exp_sp[3] = 1;

    rst_n = 1'b0; step = 1'b0; step_s = 1'b0; syn_data_s = 8'sd127;
    for (int k = 0; k < N; k++) mem[k] = '0;
    model_reset();
    do_reset();

    // Table: free decay, drive-to-spike, refractory; stray step at cycle 5,
    // back-to-back step at cycle 19 between entries 1 and 2
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < N; k++) mem[k] = '0;
      mem[3] = 8'(tbl[i].in3);
      run_sweep((i == 0) ? 5 : 0, (i == 1), (i == 2));
      chk($sformatf("tbl%0d_v3", i), got_v[3], tbl[i].exp_v3);
      chk($sformatf("tbl%0d_sp3", i), got_sp[3], tbl[i].exp_sp3);
      chk($sformatf("tbl%0d_v0", i), got_v[0], tbl[i].exp_v0);
    end

    // Randomized sweeps against the model
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) mem[k] = 8'($urandom_range(0, 255));
      run_sweep((r == 2) ? 7 : 0, 1'b0, 1'b0);
    end

    // Reset in the middle of a sweep
    @(negedge clk);
    step = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) step = 1'b0;
      if (c == 8) rst_n = 1'b1;
    end
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_syn_rd", int'(syn_rd), 0);
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < N; k++) mem[k] = '0;
    run_sweep(0, 1'b0, 1'b0);
    chk("midrst_v7", got_v[7], -14);
    chk("midrst_v15", got_v[15], -14);

    // Saturation on the V_PEAK=127 instance, neuron 0
    for (int s = 0; s < 4; s++) begin
      gv = 999; gs = -1;
      @(negedge clk);
      step_s = 1'b1;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (c == 1) step_s = 1'b0;
        if (out_valid_s && out_idx_s == 1'b0) begin
          gv = int'(v_out_s);
          gs = int'(spike_s);
        end
      end
      chk($sformatf("sat%0d_v", s), gv, sat_exp_v[s]);
      chk($sformatf("sat%0d_spike", s), gs, sat_exp_sp[s]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic unused_sat;
  assign unused_sat = syn_rd_s ^ busy_s ^ done_s ^ syn_addr_s[0];

endmodule
`default_nettype wire
